// File: rtl/uart_packet_tx.sv
// Packet framer and 8N1 serializer: buffers payload bytes, then sends
// checksum, address, count and data bytes on UART_TX.
module uart_packet_tx #(
    parameter int CLKS_PER_BIT = 100,
    parameter int DEPTH        = 16
) (
    input  logic       clk,
    input  logic       RESET_N,
    input  logic [7:0] addr,
    input  logic [7:0] data,
    input  logic       write,
    input  logic       send,
    output logic       busy,
    output logic       done,
    output logic       overflow,
    output logic       UART_TX,
    output logic [2:0] tx_state
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CKSUM = 3'd1,
        ADDR  = 3'd2,
        COUNT = 3'd3,
        DATA  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [3:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [CW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      sum_q, sum_d;
    logic [7:0]      last_q, last_d;
    logic [7:0]      addr_q, addr_d;
    logic            tx_q, tx_d;
    logic            done_q, done_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      buf_q [DEPTH];

    logic            wr_accept;
    logic [CW-1:0]   count_w;
    logic [7:0]      sum_w;
    logic [7:0]      last_w;
    logic [7:0]      cksum;
    logic [3:0]      bit_m1;

    always_ff @(posedge clk) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sum_q    <= '0;
            last_q   <= '0;
            addr_q   <= '0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            sum_q    <= sum_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            buf_q[count_q[AW-1:0]] <= data;
        end
    end

    // A write in the same idle cycle as send is folded into the packet first.
    always_comb begin
        wr_accept = write && (state_q == IDLE) && (count_q != FULL);
        count_w   = count_q + CW'(wr_accept);
        sum_w     = wr_accept ? (sum_q + data) : sum_q;
        last_w    = wr_accept ? data : last_q;
        cksum     = 8'd0 - (addr + 8'(count_w) + sum_w - last_w);

        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        sum_d    = sum_q;
        last_d   = last_q;
        addr_d   = addr_q;
        ovf_d    = ovf_q | (write && ((state_q != IDLE) || (count_q == FULL)));

        if (state_q == IDLE) begin
            count_d = count_w;
            sum_d   = sum_w;
            last_d  = last_w;
            if (send && (count_w != '0)) begin
                state_d  = CKSUM;
                addr_d   = addr;
                shift_d  = cksum;
                bit_d    = 4'd0;
                tick_d   = TICK_MAX;
                rd_ptr_d = '0;
            end
        end else if (tick_q != '0) begin
            tick_d = tick_q - TW'(1);
        end else begin
            tick_d = TICK_MAX;
            if (bit_q != 4'd9) begin
                bit_d = bit_q + 4'd1;
            end else begin
                bit_d = 4'd0;
                case (state_q)
                    CKSUM: begin
                        state_d = ADDR;
                        shift_d = addr_q;
                    end
                    ADDR: begin
                        state_d = COUNT;
                        shift_d = 8'(count_q);
                    end
                    COUNT: begin
                        state_d  = DATA;
                        shift_d  = buf_q[0];
                        rd_ptr_d = CW'(1);
                    end
                    DATA: begin
                        if (rd_ptr_q == count_q) begin
                            state_d = IDLE;
                            count_d = '0;
                            sum_d   = '0;
                            last_d  = '0;
                        end else begin
                            shift_d  = buf_q[rd_ptr_q[AW-1:0]];
                            rd_ptr_d = rd_ptr_q + CW'(1);
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // The line level is registered from next-state values so UART_TX never glitches.
    always_comb begin
        bit_m1 = bit_d - 4'd1;
        done_d = (state_q != IDLE) && (state_d == IDLE);
        if (state_d == IDLE) begin
            tx_d = 1'b1;
        end else if (bit_d == 4'd0) begin
            tx_d = 1'b0;
        end else if (bit_d == 4'd9) begin
            tx_d = 1'b1;
        end else begin
            tx_d = shift_d[bit_m1[2:0]];
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign overflow = ovf_q;
    assign UART_TX  = tx_q;
    assign tx_state = state_q;

endmodule

// File: tb/tb_uart_packet_tx.sv
// Self-checking bench for uart_packet_tx: a queue-based packet model predicts
// each frame, and the serial line is decoded at bit midpoints.
module tb_uart_packet_tx;

    localparam int CPB   = 8;
    localparam int DEPTH = 16;

    logic       clk;
    logic       RESET_N;
    logic [7:0] addr;
    logic [7:0] data;
    logic       write;
    logic       send;
    logic       busy;
    logic       done;
    logic       overflow;
    logic       UART_TX;
    logic [2:0] tx_state;

    int checkCount = 0;
    int errorCount = 0;

    logic [7:0] modelBuf[$];
    logic [7:0] expPkt[$];
    bit         modelOvf;
    logic       rxBits [0:199];

    uart_packet_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .RESET_N(RESET_N),
        .addr(addr),
        .data(data),
        .write(write),
        .send(send),
        .busy(busy),
        .done(done),
        .overflow(overflow),
        .UART_TX(UART_TX),
        .tx_state(tx_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected)
        else begin
            errorCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Packet as the link defines it: checksum excludes the final data byte.
    function automatic void modelCommit(input logic [7:0] a);
        logic [7:0] s;
        int n;
        n = modelBuf.size();
        s = a + 8'(n);
        for (int i = 0; i < n - 1; i++) s = s + modelBuf[i];
        expPkt.delete();
        expPkt.push_back(8'd0 - s);
        expPkt.push_back(a);
        expPkt.push_back(8'(n));
        foreach (modelBuf[i]) expPkt.push_back(modelBuf[i]);
        modelBuf.delete();
    endfunction

    task automatic applyStimulus(input logic w, input logic [7:0] d, input logic s,
                                 input logic [7:0] a, output bit committed);
        @(negedge clk);
        write = w;
        data  = d;
        send  = s;
        addr  = a;
        committed = 1'b0;
        if (w) begin
            if (modelBuf.size() < DEPTH) modelBuf.push_back(d);
            else modelOvf = 1'b1;
        end
        if (s && modelBuf.size() > 0) begin
            modelCommit(a);
            committed = 1'b1;
        end
        @(posedge clk);
        #1;
        write = 1'b0;
        send  = 1'b0;
    endtask

    // Called just after the edge that accepted send; decodes and checks one packet.
    task automatic runPacket(input string tag, input bit midWrite, input bit midSend,
                             input bit doneWrite, input logic [7:0] doneData);
        int nb;
        int plen;
        int busyCnt;
        int donePulses;
        int badFrames;
        logic [7:0] rx;
        nb = expPkt.size();
        plen = nb * 10 * CPB;
        busyCnt = 0;
        donePulses = 0;
        badFrames = 0;
        for (int i = 0; i <= plen + 1; i++) begin
            @(negedge clk);
            write = 1'b0;
            send  = 1'b0;
            if (busy) busyCnt++;
            if (done) donePulses++;
            if (i < plen && (i % CPB) == CPB / 2) rxBits[i / CPB] = UART_TX;
            if (i == plen) begin
                checkOutput({tag, " done"}, 32'(done), 32'd1);
                checkOutput({tag, " idle line"}, 32'(UART_TX), 32'd1);
            end
            if (midWrite && i == 5 * CPB) begin
                write = 1'b1;
                data  = 8'hEE;
                modelOvf = 1'b1;
            end
            if (midSend && i == 7 * CPB) begin
                send = 1'b1;
                addr = 8'h99;
            end
            if (doneWrite && i == plen) begin
                write = 1'b1;
                data  = doneData;
                modelBuf.push_back(doneData);
            end
        end
        write = 1'b0;
        for (int j = 0; j < nb; j++) begin
            for (int k = 0; k < 8; k++) rx[k] = rxBits[j * 10 + 1 + k];
            if (rxBits[j * 10] !== 1'b0 || rxBits[j * 10 + 9] !== 1'b1) badFrames++;
            checkOutput($sformatf("%s byte%0d", tag, j), 32'(rx), 32'(expPkt[j]));
        end
        checkOutput({tag, " framing"}, 32'(badFrames), 32'd0);
        checkOutput({tag, " busy cycles"}, 32'(busyCnt), 32'(plen));
        checkOutput({tag, " done pulses"}, 32'(donePulses), 32'd1);
        checkOutput({tag, " overflow"}, 32'(overflow), 32'(modelOvf));
        checkOutput({tag, " state"}, 32'(tx_state), 32'd0);
    endtask

    initial begin
        bit c;
        int n;
        logic [7:0] a;
        bit combine;

        RESET_N = 1'b0;
        write = 1'b0;
        send = 1'b0;
        addr = 8'h00;
        data = 8'h00;
        modelOvf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset UART_TX", 32'(UART_TX), 32'd1);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset overflow", 32'(overflow), 32'd0);
        checkOutput("reset state", 32'(tx_state), 32'd0);
        @(negedge clk);
        RESET_N = 1'b1;

        $display("[TB] single-byte packet");
        applyStimulus(1'b1, 8'h5A, 1'b0, 8'h00, c);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h10, c);
        runPacket("single", 1'b0, 1'b0, 1'b0, 8'h00);

        $display("[TB] three-byte packet");
        applyStimulus(1'b1, 8'h01, 1'b0, 8'h00, c);
        applyStimulus(1'b1, 8'h02, 1'b0, 8'h00, c);
        applyStimulus(1'b1, 8'h03, 1'b0, 8'h00, c);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h20, c);
        runPacket("three", 1'b0, 1'b0, 1'b0, 8'h00);

        applyStimulus(1'b0, 8'h00, 1'b1, 8'h44, c);
        checkOutput("empty send busy", 32'(busy), 32'd0);
        checkOutput("empty send state", 32'(tx_state), 32'd0);
        checkOutput("empty send overflow", 32'(overflow), 32'd0);

        $display("[TB] overflow packet");
        for (int i = 0; i <= DEPTH; i++) applyStimulus(1'b1, 8'(i), 1'b0, 8'h00, c);
        checkOutput("overflow set", 32'(overflow), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h40, c);
        runPacket("full", 1'b1, 1'b1, 1'b1, 8'h3C);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h41, c);
        runPacket("after done write", 1'b0, 1'b0, 1'b0, 8'h00);

        $display("[TB] write and send together");
        applyStimulus(1'b1, 8'h77, 1'b1, 8'h01, c);
        runPacket("write+send", 1'b0, 1'b0, 1'b0, 8'h00);

        $display("[TB] reset during data");
        applyStimulus(1'b1, 8'h11, 1'b0, 8'h00, c);
        applyStimulus(1'b1, 8'h22, 1'b0, 8'h00, c);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h50, c);
        repeat (34 * CPB + 3) @(negedge clk);
        checkOutput("pre-reset state", 32'(tx_state), 32'd4);
        RESET_N = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort UART_TX", 32'(UART_TX), 32'd1);
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort state", 32'(tx_state), 32'd0);
        checkOutput("abort overflow", 32'(overflow), 32'd0);
        modelBuf.delete();
        expPkt.delete();
        modelOvf = 1'b0;
        @(negedge clk);
        RESET_N = 1'b1;
        applyStimulus(1'b1, 8'hAA, 1'b0, 8'h00, c);
        applyStimulus(1'b1, 8'h55, 1'b0, 8'h00, c);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h30, c);
        runPacket("post-reset", 1'b0, 1'b0, 1'b0, 8'h00);

        $display("[TB] randomized packets");
        for (int r = 0; r < 5; r++) begin
            n = $urandom_range(1, DEPTH);
            a = 8'($urandom);
            combine = 1'($urandom);
            for (int i = 0; i < n - 1; i++) applyStimulus(1'b1, 8'($urandom), 1'b0, 8'h00, c);
            if (combine) begin
                applyStimulus(1'b1, 8'($urandom), 1'b1, a, c);
            end else begin
                applyStimulus(1'b1, 8'($urandom), 1'b0, 8'h00, c);
                applyStimulus(1'b0, 8'h00, 1'b1, a, c);
            end
            runPacket($sformatf("random%0d", r), 1'b0, 1'($urandom), 1'b0, 8'h00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
